// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry pipeline register (MAIN + SKID) with valid/ready handshake.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream), flush (sync discard),
//        occ (held entries 0..2), stall_cnt (saturating back-pressure cycle count).
module pipe_stage_skid #(
   parameter int DW = 32,
   parameter int NCH = 7,
   parameter logic [DW-1:0] NOP = 32'h00000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NCH*DW-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH*DW-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occ,
   output logic [15:0]       stall_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   localparam logic [NCH*DW-1:0] RST_MAIN = {{(NCH-1)*DW{1'b0}}, NOP};
   state_t state;
   logic [NCH*DW-1:0] main_q, skid_q;
   logic accept, pop;
   // handshake outputs decode registered state only, so in_ready never sees out_ready
   assign in_ready  = state != FULL;
   assign out_valid = state != EMPTY;
   assign occ       = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         main_q    <= RST_MAIN;
         skid_q    <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush) begin
            state          <= EMPTY;
            main_q[DW-1:0] <= NOP;
         end else begin
            case (state)
               EMPTY: if (accept) begin
                  state  <= ONE;
                  main_q <= in_data;
               end
               ONE: if (accept && pop) begin
                  main_q <= in_data;
               end else if (accept) begin
                  state  <= FULL;
                  skid_q <= in_data;
               end else if (pop) begin
                  // bubble shows NOP on channel 0; other channels keep their last values
                  state          <= EMPTY;
                  main_q[DW-1:0] <= NOP;
               end
               FULL: if (pop) begin
                  state  <= ONE;
                  main_q <= skid_q;
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DW, default 32, meaning width of one channel in bits.
REQ-002 SHALL have parameter NCH, default 7, meaning number of channels carried per entry (IR, PC, PC4, PC8, AO, MDO, RT).
REQ-003 SHALL have parameter NOP, default 32'h00000000, meaning channel-0 value presented when the stage is empty (bubble).
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-008 SHALL have port in_data  input  NCH*DW  upstream entry; channel k at bits [k*DW +: DW].
REQ-009 SHALL have port out_valid  output  1  entry present at output.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the output entry this cycle.
REQ-011 SHALL have port out_data  output  NCH*DW  output entry, same channel packing.
REQ-012 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-013 SHALL have port occ  output  2  number of held entries (0..2).
REQ-014 SHALL have port stall_cnt  output  16  saturating count of back-pressure cycles.

Function
REQ-015 SHALL hold two entry registers, MAIN and SKID, under a state machine with states EMPTY (occ=0), ONE (MAIN valid, occ=1) and FULL (MAIN and SKID valid, occ=2).
REQ-016 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-018 SHALL drive out_valid = (state != EMPTY) and out_data = MAIN.
REQ-019 SHALL transition EMPTY on accept: -> ONE, MAIN <= in_data.
REQ-020 SHALL transition ONE on accept & pop: stay ONE, MAIN <= in_data.
REQ-021 SHALL transition ONE on accept & !pop: -> FULL, SKID <= in_data, MAIN unchanged.
REQ-022 SHALL transition ONE on !accept & pop: -> EMPTY.
REQ-023 SHALL transition FULL on pop: -> ONE, MAIN <= SKID.
REQ-024 SHALL leave state and registers unchanged in every case not listed in REQ-019 to REQ-023.
REQ-025 SHALL, on entering EMPTY, load MAIN channel 0 with NOP and leave channels 1..NCH-1 holding their last values.
REQ-026 SHALL give flush the highest priority: next state EMPTY, MAIN channel 0 <= NOP, any same-cycle accept discarded, any same-cycle pop still counted as delivered by downstream.
REQ-027 SHALL give a latency of exactly 1 cycle from accept to out_valid when the stage is EMPTY.
REQ-028 SHALL sustain 1 entry/cycle throughput while out_ready=1.
REQ-029 SHALL deliver entries in order, never lose an entry except by flush, and never duplicate an entry.
REQ-030 SHALL increment stall_cnt by 1 on each cycle with out_valid=1 & out_ready=0, saturate at 16'hFFFF, and leave it unaffected by flush.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state EMPTY, occ=0, stall_cnt=0, MAIN channel 0 = NOP, all other MAIN channels and all SKID channels = 0, out_valid=0, in_ready=1.
REQ-032 SHALL reach its reset values within the same cycle when reset is asserted mid-transfer, with no entry surviving.
REQ-033 SHALL take its first transition on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL pass the streaming test: reset, then in_valid=1 with channel0 = 1,2,3,4 on successive cycles and out_ready=1 -> out_data ch0 = 1,2,3,4 one cycle later each, occ=1 throughout, stall_cnt=0.
REQ-035 SHALL pass the back-pressure test: out_ready=0 while sending entries A and B -> occ goes 1 then 2, in_ready=0 after B; out_ready=1 for 2 cycles -> output A then B, occ 2->1->0.
REQ-036 SHALL pass the flush test: state FULL, flush=1 with in_valid=1 -> next cycle occ=0, out_valid=0, ch0=NOP, and the flushed-cycle input never appears at the output.
REQ-037 SHALL pass the async reset test: assert reset=0 mid-cycle while FULL -> out_valid=0, occ=0, in_ready=1 with no clock edge required.
REQ-038 SHALL pass the stall counter test: hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF with no wrap.
REQ-039 SHALL pass the random test: random in_valid and out_ready over 10000 cycles against a scoreboard -> in-order delivery, no loss or duplication, and in_ready never depends combinationally on out_ready.
